// File: rtl/execute_stage_pkg.sv
// Y86 execute-stage shared definitions: instruction/ALU codes and the branch/cmov condition evaluator.
// Rev 1.0
`default_nettype none

package execute_stage_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVL = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam logic [3:0] COND_ALWAYS = 4'h0;
  localparam logic [3:0] COND_LE     = 4'h1;
  localparam logic [3:0] COND_L      = 4'h2;
  localparam logic [3:0] COND_E      = 4'h3;
  localparam logic [3:0] COND_NE     = 4'h4;
  localparam logic [3:0] COND_GE     = 4'h5;
  localparam logic [3:0] COND_G      = 4'h6;

  localparam logic [3:0] REG_NONE = 4'hF;

  // cc is {ZF,SF,OF}; undefined condition codes evaluate false.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    case (fn)
      COND_ALWAYS: cond_eval = 1'b1;
      COND_LE:     cond_eval = (sf ^ of) | zf;
      COND_L:      cond_eval = sf ^ of;
      COND_E:      cond_eval = zf;
      COND_NE:     cond_eval = ~zf;
      COND_GE:     cond_eval = ~(sf ^ of);
      COND_G:      cond_eval = ~(sf ^ of) & ~zf;
      default:     cond_eval = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/y86_alu.sv
// Y86 combinational ALU: add, sub (B-A), and, xor with {ZF,SF,OF} flags.
// Rev 1.0
`default_nettype none

module y86_alu
  import execute_stage_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [WORD-1:0] aluA,
  input  logic [WORD-1:0] aluB,
  input  logic [1:0]      fn,
  output logic [WORD-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            of
);

  logic w_sa, w_sb, w_st;

  always_comb begin
    result = aluB + aluA;
    case (fn)
      ALU_SUB: result = aluB - aluA;
      ALU_AND: result = aluB & aluA;
      ALU_XOR: result = aluB ^ aluA;
      default: result = aluB + aluA;
    endcase
  end

  assign w_sa = aluA[WORD-1];
  assign w_sb = aluB[WORD-1];
  assign w_st = result[WORD-1];

  assign zf = (result == '0);
  assign sf = w_st;

  // Subtraction overflows only when the operands disagree in sign and the result flips away from B.
  always_comb begin
    of = 1'b0;
    case (fn)
      ALU_ADD: of = (w_sa == w_sb) && (w_st != w_sa);
      ALU_SUB: of = (w_sa != w_sb) && (w_st != w_sb);
      default: of = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// Y86 execute stage: operand muxing, ALU, condition evaluation, CC register and memory-stage pipeline register.
// Rev 1.0
`default_nettype none

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WORD      = 32,
  parameter int STACK_INC = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic [WORD-1:0] valA,
  input  logic [WORD-1:0] valB,
  input  logic [WORD-1:0] valC,
  input  logic [WORD-1:0] valP,
  input  logic            stall_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic [3:0]      icode_out,
  output logic [3:0]      rA_out,
  output logic [3:0]      rB_out,
  output logic [WORD-1:0] valA_out,
  output logic [WORD-1:0] valE_out,
  output logic [WORD-1:0] valP_out,
  output logic            cnd_out,
  output logic [2:0]      cc_out,
  output logic            halted,
  output logic            instr_error
);

  localparam logic [WORD-1:0] C_INC = WORD'(STACK_INC);
  localparam logic [WORD-1:0] C_DEC = ~C_INC + WORD'(1);

  logic            r_valid, r_cnd, r_halted, r_err;
  logic [3:0]      r_icode, r_ra, r_rb;
  logic [WORD-1:0] r_vala, r_vale, r_valp;
  logic [2:0]      r_cc;

  logic [WORD-1:0] w_alu_a, w_alu_b, w_alu_res, w_vale;
  logic [1:0]      w_alu_fn;
  logic            w_zf, w_sf, w_of;
  logic            w_accept, w_is_opl, w_is_cond, w_opl_bad, w_cond_bad, w_bad_icode;
  logic            w_err, w_cnd;

  always_comb begin
    w_alu_a = '0;
    case (icode)
      ICODE_RRMOVL, ICODE_OPL:                   w_alu_a = valA;
      ICODE_IRMOVL, ICODE_RMMOVL, ICODE_MRMOVL:  w_alu_a = valC;
      ICODE_CALL, ICODE_PUSHL:                   w_alu_a = C_DEC;
      ICODE_RET, ICODE_POPL:                     w_alu_a = C_INC;
      default:                                   w_alu_a = '0;
    endcase
  end

  always_comb begin
    w_alu_b = '0;
    case (icode)
      ICODE_RMMOVL, ICODE_MRMOVL, ICODE_OPL, ICODE_CALL,
      ICODE_RET, ICODE_PUSHL, ICODE_POPL:        w_alu_b = valB;
      default:                                   w_alu_b = '0;
    endcase
  end

  assign w_is_opl    = (icode == ICODE_OPL);
  assign w_is_cond   = (icode == ICODE_RRMOVL) || (icode == ICODE_JXX);
  assign w_opl_bad   = w_is_opl && (ifun > 4'd3);
  assign w_cond_bad  = w_is_cond && (ifun > COND_G);
  assign w_bad_icode = (icode > ICODE_POPL);
  assign w_err       = w_bad_icode || w_opl_bad || w_cond_bad;
  assign w_alu_fn    = w_is_opl ? ifun[1:0] : ALU_ADD;

  y86_alu #(.WORD(WORD)) u_alu (
    .aluA   (w_alu_a),
    .aluB   (w_alu_b),
    .fn     (w_alu_fn),
    .result (w_alu_res),
    .zf     (w_zf),
    .sf     (w_sf),
    .of     (w_of)
  );

  assign w_vale   = w_opl_bad ? '0 : w_alu_res;
  // Conditions read the CC register as it stood before this instruction.
  assign w_cnd    = w_is_cond ? cond_eval(ifun, r_cc) : 1'b1;
  assign w_accept = valid_in && !r_halted;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_icode  <= ICODE_NOP;
      r_ra     <= REG_NONE;
      r_rb     <= REG_NONE;
      r_vala   <= '0;
      r_vale   <= '0;
      r_valp   <= '0;
      r_cnd    <= 1'b1;
      r_cc     <= 3'b100;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else if (!stall_in) begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_icode <= icode;
        r_ra    <= rA;
        r_rb    <= (icode == ICODE_RRMOVL && !w_cnd) ? REG_NONE : rB;
        r_vala  <= valA;
        r_vale  <= w_vale;
        r_valp  <= valP;
        r_cnd   <= w_cnd;
        if (w_is_opl && !w_opl_bad)
          r_cc <= {w_zf, w_sf, w_of};
        if (icode == ICODE_HALT || w_err)
          r_halted <= 1'b1;
        if (w_err)
          r_err <= 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_icode <= ICODE_NOP;
        r_ra    <= REG_NONE;
        r_rb    <= REG_NONE;
      end
    end
  end

  assign stall_out   = stall_in || r_halted;
  assign valid_out   = r_valid;
  assign icode_out   = r_icode;
  assign rA_out      = r_ra;
  assign rB_out      = r_rb;
  assign valA_out    = r_vala;
  assign valE_out    = r_vale;
  assign valP_out    = r_valp;
  assign cnd_out     = r_cnd;
  assign cc_out      = r_cc;
  assign halted      = r_halted;
  assign instr_error = r_err;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed expectations.
// Rev 1.0
`default_nettype none

module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset, valid_in, stall_in;
  logic [3:0]  icode, ifun, rA, rB;
  logic [31:0] valA, valB, valC, valP;
  logic        stall_out, valid_out, cnd_out, halted, instr_error;
  logic [3:0]  icode_out, rA_out, rB_out;
  logic [31:0] valA_out, valE_out, valP_out;
  logic [2:0]  cc_out;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  execute_stage #(.WORD(32), .STACK_INC(4)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valA(valA), .valB(valB), .valC(valC), .valP(valP),
    .stall_in(stall_in), .stall_out(stall_out), .valid_out(valid_out),
    .icode_out(icode_out), .rA_out(rA_out), .rB_out(rB_out),
    .valA_out(valA_out), .valE_out(valE_out), .valP_out(valP_out),
    .cnd_out(cnd_out), .cc_out(cc_out), .halted(halted), .instr_error(instr_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] p);
    valid_in = v; icode = ic; ifun = fn; rA = ra; rB = rb;
    valA = a; valB = b; valC = c; valP = p;
  endtask

  // Inputs change 1 time unit after a posedge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0;
    drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_icode", 32'(icode_out), 32'h1);
    chk("rst_rb", 32'(rB_out), 32'hF);
    chk("rst_cc", 32'(cc_out), 32'h4);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stall_out", 32'(stall_out), 32'h0);
    reset = 1'b0;

    drive(1'b1, 4'h6, 4'h1, 4'h1, 4'h2, 32'h5, 32'h3, 32'h0, 32'h10);
    tick();
    chk("subl_vale", valE_out, 32'hFFFFFFFE);
    chk("subl_cc", 32'(cc_out), 32'h2);
    chk("subl_valid", 32'(valid_out), 32'h1);
    chk("subl_icode", 32'(icode_out), 32'h6);

    drive(1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h12);
    tick();
    chk("addl_vale", valE_out, 32'h80000000);
    chk("addl_cc", 32'(cc_out), 32'h3);

    drive(1'b1, 4'h6, 4'h3, 4'h1, 4'h2, 32'h5, 32'h5, 32'h0, 32'h14);
    tick();
    chk("xorl_vale", valE_out, 32'h0);
    chk("xorl_cc", 32'(cc_out), 32'h4);

    drive(1'b1, 4'h2, 4'h1, 4'h1, 4'h3, 32'h1234, 32'h9, 32'h0, 32'h16);
    tick();
    chk("cmovle_cnd", 32'(cnd_out), 32'h1);
    chk("cmovle_rb", 32'(rB_out), 32'h3);
    chk("cmovle_vale", valE_out, 32'h1234);

    drive(1'b1, 4'h2, 4'h6, 4'h1, 4'h3, 32'h55, 32'h9, 32'h0, 32'h18);
    tick();
    chk("cmovg_cnd", 32'(cnd_out), 32'h0);
    chk("cmovg_rb", 32'(rB_out), 32'hF);
    chk("cmovg_vale", valE_out, 32'h55);
    chk("cmovg_cc", 32'(cc_out), 32'h4);

    drive(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, 32'h0, 32'h0, 32'h80, 32'h1A);
    tick();
    chk("je_cnd", 32'(cnd_out), 32'h1);
    drive(1'b1, 4'h7, 4'h4, 4'hF, 4'hF, 32'h0, 32'h0, 32'h80, 32'h1F);
    tick();
    chk("jne_cnd", 32'(cnd_out), 32'h0);

    drive(1'b1, 4'hA, 4'h0, 4'h1, 4'h4, 32'h7, 32'h100, 32'h0, 32'h20);
    tick();
    chk("pushl_vale", valE_out, 32'h000000FC);
    chk("pushl_cnd", 32'(cnd_out), 32'h1);
    drive(1'b1, 4'h8, 4'h0, 4'hF, 4'h4, 32'h0, 32'h100, 32'h40, 32'h25);
    tick();
    chk("call_vale", valE_out, 32'h000000FC);
    chk("call_valp", valP_out, 32'h25);
    drive(1'b1, 4'hB, 4'h0, 4'h1, 4'h4, 32'h100, 32'h100, 32'h0, 32'h2A);
    tick();
    chk("popl_vale", valE_out, 32'h00000104);
    drive(1'b1, 4'h9, 4'h0, 4'hF, 4'h4, 32'h100, 32'h100, 32'h0, 32'h2B);
    tick();
    chk("ret_vale", valE_out, 32'h00000104);
    drive(1'b1, 4'h5, 4'h0, 4'h2, 4'h4, 32'h0, 32'h100, 32'h8, 32'h30);
    tick();
    chk("mrmovl_vale", valE_out, 32'h00000108);
    chk("mrmovl_ra", 32'(rA_out), 32'h2);

    drive(1'b0, 4'h6, 4'h0, 4'h1, 4'h2, 32'h1, 32'h1, 32'h0, 32'h0);
    tick();
    chk("bubble_valid", 32'(valid_out), 32'h0);
    chk("bubble_icode", 32'(icode_out), 32'h1);
    chk("bubble_rb", 32'(rB_out), 32'hF);
    chk("bubble_cc", 32'(cc_out), 32'h4);

    drive(1'b1, 4'h3, 4'h0, 4'hF, 4'h4, 32'h0, 32'h0, 32'hAA, 32'h36);
    tick();
    chk("irmovl_vale", valE_out, 32'hAA);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h6, 4'h1, 4'h1, 4'h2, 32'(i + 9), 32'h1, 32'h0, 32'(i));
      tick();
      chk("stall_vale", valE_out, 32'hAA);
      chk("stall_icode", 32'(icode_out), 32'h3);
      chk("stall_cc", 32'(cc_out), 32'h4);
      chk("stall_out", 32'(stall_out), 32'h1);
    end
    stall_in = 1'b0;
    drive(1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 32'h1, 32'h2, 32'h0, 32'h40);
    tick();
    chk("release_vale", valE_out, 32'h3);
    chk("release_cc", 32'(cc_out), 32'h0);

    drive(1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 32'h0, 32'h42);
    tick();
    chk("halt_icode", 32'(icode_out), 32'h0);
    chk("halt_valid", 32'(valid_out), 32'h1);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_stall_out", 32'(stall_out), 32'h1);
    drive(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 32'h0, 32'h43);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_halt_valid", 32'(valid_out), 32'h0);
      chk("post_halt_icode", 32'(icode_out), 32'h1);
    end
    chk("halt_no_err", 32'(instr_error), 32'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 4'hC, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 32'h0, 32'h50);
    tick();
    chk("bad_icode_err", 32'(instr_error), 32'h1);
    chk("bad_icode_halted", 32'(halted), 32'h1);
    chk("bad_icode_out", 32'(icode_out), 32'hC);

    stall_in = 1'b1; reset = 1'b1;
    tick();
    chk("rst_stall_valid", 32'(valid_out), 32'h0);
    chk("rst_stall_icode", 32'(icode_out), 32'h1);
    chk("rst_stall_halted", 32'(halted), 32'h0);
    chk("rst_stall_err", 32'(instr_error), 32'h0);
    chk("rst_stall_cc", 32'(cc_out), 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
